// File: rtl/board_ram_arbiter_if.sv
// Bus bundle between the board RAM arbiter, its three requesters
// and the single-port playfield RAM.
interface board_ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  vga_req, vga_addr,
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_rdata,
    output vga_gnt, vga_rvalid,
    output m0_gnt, m0_rvalid,
    output m1_gnt, m1_rvalid,
    output rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vga_req, vga_addr,
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_rdata,
    input  vga_gnt, vga_rvalid,
    input  m0_gnt, m0_rvalid,
    input  m1_gnt, m1_rvalid,
    input  rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: VGA priority, m0/m1 round-robin, starvation override.
// Optional ARB_STATS_EN adds saturating defer/wait statistics counters.
module board_ram_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic clk_clk,
  input  logic reset_reset,
  board_ram_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_vga_defer,
  output logic [15:0] stat_game_wait
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SEL_NONE, SEL_VGA, SEL_M0, SEL_M1
  } sel_e;

  sel_e sel;
  logic game_req, pick_m1, starved, game_gnt;
  logic rr_q, rr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // one-hot {m1, m0, vga}
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] rd_q, rd_d;
  logic [2:0] rv_q;

  always_comb begin
    game_req = bus.m0_req | bus.m1_req;
    pick_m1  = bus.m1_req & (~bus.m0_req | rr_q);
    starved  = starve_q >= SW'(STARVE_LIMIT);
    sel      = SEL_NONE;
    if (starved && game_req)
      sel = pick_m1 ? SEL_M1 : SEL_M0;
    else if (bus.vga_req)
      sel = SEL_VGA;
    else if (game_req)
      sel = pick_m1 ? SEL_M1 : SEL_M0;
    game_gnt = (sel == SEL_M0) || (sel == SEL_M1);
  end

  always_comb begin
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    gnt_d   = 3'b000;
    rd_d    = 3'b000;
    rr_d    = rr_q;
    unique case (sel)
      SEL_VGA: begin
        addr_d = bus.vga_addr;
        gnt_d  = 3'b001;
        rd_d   = 3'b001;
      end
      SEL_M0: begin
        addr_d  = bus.m0_addr;
        we_d    = bus.m0_we;
        wdata_d = bus.m0_wdata;
        gnt_d   = 3'b010;
        rd_d    = bus.m0_we ? 3'b000 : 3'b010;
        rr_d    = 1'b1;
      end
      SEL_M1: begin
        addr_d  = bus.m1_addr;
        we_d    = bus.m1_we;
        wdata_d = bus.m1_wdata;
        gnt_d   = 3'b100;
        rd_d    = bus.m1_we ? 3'b000 : 3'b100;
        rr_d    = 1'b0;
      end
      default: ;
    endcase
    if (!game_req || game_gnt)
      starve_d = '0;
    else if (!starved)
      starve_d = starve_q + SW'(1);
    else
      starve_d = starve_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      rd_q     <= '0;
      rv_q     <= '0;
      rr_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      rd_q     <= rd_d;
      rv_q     <= rd_q;
      rr_q     <= rr_d;
      starve_q <= starve_d;
    end
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_we     = we_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.rdata      = bus.ram_rdata;
  assign bus.vga_gnt    = gnt_q[0];
  assign bus.m0_gnt     = gnt_q[1];
  assign bus.m1_gnt     = gnt_q[2];
  assign bus.vga_rvalid = rv_q[0];
  assign bus.m0_rvalid  = rv_q[1];
  assign bus.m1_rvalid  = rv_q[2];

`ifdef ARB_STATS_EN
  logic [15:0] vdef_q, gwait_q;
  logic vdef_inc, gwait_inc;

  assign vdef_inc  = bus.vga_req && (sel != SEL_VGA);
  assign gwait_inc = game_req && !game_gnt;

  always_ff @(posedge clk_clk) begin
    if (reset_reset || stat_clr) begin
      vdef_q  <= '0;
      gwait_q <= '0;
    end else begin
      if (vdef_inc && vdef_q != 16'hFFFF)
        vdef_q <= vdef_q + 16'd1;
      if (gwait_inc && gwait_q != 16'hFFFF)
        gwait_q <= gwait_q + 16'd1;
    end
  end

  assign stat_vga_defer = vdef_q;
  assign stat_game_wait = gwait_q;
`endif
endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter with a behavioural 1-cycle RAM.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_board_ram_arbiter;
  logic clk_clk = 1'b0;
  logic reset_reset;
  int checks = 0;
  int errors = 0;

  always #5 clk_clk = ~clk_clk;

  board_ram_arbiter_if #(.ADDR_W(8), .DATA_W(4)) bus ();

`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_vga_defer;
  logic [15:0] stat_game_wait;
`endif

  board_ram_arbiter #(
    .ADDR_W(8), .DATA_W(4), .STARVE_LIMIT(16)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .bus        (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_clr      (stat_clr),
    .stat_vga_defer(stat_vga_defer),
    .stat_game_wait(stat_game_wait)
`endif
  );

  logic [3:0] mem [256];
  logic       pl_en;
  logic [7:0] pl_addr;
  logic [3:0] pl_data;

  always @(posedge clk_clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.vga_req  = 1'b0; bus.vga_addr = '0;
    bus.m0_req   = 1'b0; bus.m0_we    = 1'b0;
    bus.m0_addr  = '0;   bus.m0_wdata = '0;
    bus.m1_req   = 1'b0; bus.m1_we    = 1'b0;
    bus.m1_addr  = '0;   bus.m1_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_reset = 1'b1;
    step();
    step();
    reset_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.vga_gnt, bus.m0_gnt, bus.m1_gnt} !== 3'b000) begin
      errors++;
      $display("FAIL reset_gnt: got %b want 000",
        {bus.vga_gnt, bus.m0_gnt, bus.m1_gnt});
    end
    checks++;
    if ({bus.vga_rvalid, bus.m0_rvalid, bus.m1_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rvalid: got %b want 000",
        {bus.vga_rvalid, bus.m0_rvalid, bus.m1_rvalid});
    end
    checks++;
    if ({bus.ram_we, bus.ram_addr, bus.ram_wdata} !== 13'd0) begin
      errors++;
      $display("FAIL reset_ram: we %b addr %0d wdata %0h want 0 0 0",
        bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'd5;
    step();
    checks++;
    if (bus.m0_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rmr_gnt: got %b want 1", bus.m0_gnt);
    end
    bus.m0_req = 1'b0;
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    checks++;
    if ({bus.m0_rvalid, bus.m0_gnt, bus.ram_we, bus.ram_addr} !== 11'd0) begin
      errors++;
      $display("FAIL rmr_after: rv %b gnt %b we %b addr %0d want 0",
        bus.m0_rvalid, bus.m0_gnt, bus.ram_we, bus.ram_addr);
    end
    step();
    checks++;
    if (bus.m0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rmr_no_rvalid: got %b want 0", bus.m0_rvalid);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    pl_en = 1'b1; pl_addr = 8'd37; pl_data = 4'hA;
    step();
    pl_en = 1'b0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'd37;
    step();
    checks++;
    if ({bus.m1_gnt, bus.ram_we, bus.ram_addr} !== {2'b10, 8'd37}) begin
      errors++;
      $display("FAIL srd_gnt: gnt %b we %b addr %0d want 1 0 37",
        bus.m1_gnt, bus.ram_we, bus.ram_addr);
    end
    bus.m1_req = 1'b0;
    step();
    checks++;
    if ({bus.m1_rvalid, bus.rdata} !== 5'b1_1010) begin
      errors++;
      $display("FAIL srd_data: rvalid %b rdata %h want 1 a",
        bus.m1_rvalid, bus.rdata);
    end
    step();
    checks++;
    if ({bus.m1_rvalid, bus.m1_gnt, bus.ram_we} !== 3'b000) begin
      errors++;
      $display("FAIL srd_idle: rv %b gnt %b we %b want 000",
        bus.m1_rvalid, bus.m1_gnt, bus.ram_we);
    end
    checks++;
    if (bus.ram_addr !== 8'd37) begin
      errors++;
      $display("FAIL srd_hold: addr %0d want 37", bus.ram_addr);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    bus.m0_req = 1'b1; bus.m0_we = 1'b1;
    bus.m0_addr = 8'd12; bus.m0_wdata = 4'h5;
    step();
    checks++;
    if ({bus.m0_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata}
        !== {2'b11, 8'd12, 4'h5}) begin
      errors++;
      $display("FAIL wr_issue: gnt %b we %b addr %0d wd %h want 1 1 12 5",
        bus.m0_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    bus.m0_we = 1'b0;
    step();
    checks++;
    if ({bus.m0_gnt, bus.ram_we, bus.m0_rvalid, bus.ram_addr}
        !== {3'b100, 8'd12}) begin
      errors++;
      $display("FAIL rd_issue: gnt %b we %b rv %b addr %0d want 1 0 0 12",
        bus.m0_gnt, bus.ram_we, bus.m0_rvalid, bus.ram_addr);
    end
    bus.m0_req = 1'b0;
    step();
    checks++;
    if ({bus.m0_rvalid, bus.rdata, bus.m0_gnt} !== 6'b1_0101_0) begin
      errors++;
      $display("FAIL wr_rd_data: rv %b rdata %h gnt %b want 1 5 0",
        bus.m0_rvalid, bus.rdata, bus.m0_gnt);
    end
  endtask

  task automatic test_vga_priority();
    logic [2:0] want [4];
    logic [7:0] wadr [4];
    want[0] = 3'b100; want[1] = 3'b010;
    want[2] = 3'b001; want[3] = 3'b010;
    wadr[0] = 8'd3; wadr[1] = 8'd1;
    wadr[2] = 8'd2; wadr[3] = 8'd1;
    do_reset();
    bus.vga_req = 1'b1; bus.vga_addr = 8'd3;
    bus.m0_req  = 1'b1; bus.m0_addr  = 8'd1;
    bus.m1_req  = 1'b1; bus.m1_addr  = 8'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.vga_req = 1'b0;
      checks++;
      if ({bus.vga_gnt, bus.m0_gnt, bus.m1_gnt, bus.ram_addr}
          !== {want[i], wadr[i]}) begin
        errors++;
        $display("FAIL prio_%0d: gnt %b addr %0d want %b %0d", i,
          {bus.vga_gnt, bus.m0_gnt, bus.m1_gnt}, bus.ram_addr,
          want[i], wadr[i]);
      end
    end
    checks++;
    if (bus.vga_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL prio_rvalid: vga %b m1 %b want 0 1",
        bus.vga_rvalid, bus.m1_rvalid);
    end
    clear_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    bus.vga_req = 1'b1; bus.vga_addr = 8'd7;
    bus.m1_req  = 1'b1; bus.m1_addr  = 8'd9;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if ({bus.vga_gnt, bus.m1_gnt} !== 2'b10) begin
        errors++;
        $display("FAIL starve_vga_%0d: vga %b m1 %b want 1 0",
          i, bus.vga_gnt, bus.m1_gnt);
      end
      if (i > 0) begin
        checks++;
        if (bus.vga_rvalid !== 1'b1) begin
          errors++;
          $display("FAIL pipe_rv_%0d: got %b want 1", i, bus.vga_rvalid);
        end
      end
    end
    step();
    checks++;
    if ({bus.vga_gnt, bus.m1_gnt, bus.ram_addr} !== {2'b01, 8'd9}) begin
      errors++;
      $display("FAIL starve_m1: vga %b m1 %b addr %0d want 0 1 9",
        bus.vga_gnt, bus.m1_gnt, bus.ram_addr);
    end
    bus.m1_req = 1'b0;
    step();
    checks++;
    if ({bus.vga_gnt, bus.m1_gnt, bus.m1_rvalid} !== 3'b101) begin
      errors++;
      $display("FAIL starve_resume: vga %b m1 %b m1rv %b want 1 0 1",
        bus.vga_gnt, bus.m1_gnt, bus.m1_rvalid);
    end
    step();
    step();
`ifdef ARB_STATS_EN
    checks++;
    if (stat_game_wait !== 16'd16 || stat_vga_defer !== 16'd1) begin
      errors++;
      $display("FAIL stats: wait %0d defer %0d want 16 1",
        stat_game_wait, stat_vga_defer);
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    checks++;
    if (stat_game_wait !== 16'd0 || stat_vga_defer !== 16'd0) begin
      errors++;
      $display("FAIL stats_clr: wait %0d defer %0d want 0 0",
        stat_game_wait, stat_vga_defer);
    end
`endif
    clear_inputs();
  endtask

  initial begin
    reset_reset = 1'b1;
    clear_inputs();
    test_reset();
    test_reset_mid_read();
    test_single_read();
    test_write_read();
    test_vga_priority();
    test_starvation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview: Arbitrates one single-port board/tile RAM among three requesters: VGA scanout fetch (read-only, priority), line-clear engine (m0) and piece writer (m1). It sits between the game-logic datapath and the playfield RAM that feeds the VGA port. Fixed priority applies to VGA, round-robin applies between m0 and m1, and a starvation counter guarantees game-logic progress.

Parameters:
ADDR_W, 8, RAM address width (10x20 board = 200 cells)
DATA_W, 4, cell data width (colour index)
STARVE_LIMIT, 16, consecutive denied cycles before a pending game request overrides VGA (>=2)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous active-high reset
vga_req  in  1  VGA read request
vga_addr  in  ADDR_W  VGA read address
vga_gnt  out  1  one-cycle grant pulse
vga_rvalid  out  1  VGA read data valid
m0_req, m1_req  in  1  game requester request
m0_we, m1_we  in  1  1=write, 0=read
m0_addr, m1_addr  in  ADDR_W  address
m0_wdata, m1_wdata  in  DATA_W  write data
m0_gnt, m1_gnt  out  1  one-cycle grant pulse
m0_rvalid, m1_rvalid  out  1  read data valid
rdata  out  DATA_W  shared read data, equal to ram_rdata
ram_addr  out  ADDR_W  registered RAM address
ram_we  out  1  registered RAM write enable
ram_wdata  out  DATA_W  registered RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_addr

Behaviour:
- Reset (sync, reset_reset=1): all gnt/rvalid=0, ram_we=0, ram_addr=0, ram_wdata=0, rr pointer=m0, starve counter=0. Any in-flight read is cancelled; no rvalid is issued in the cycle after reset deasserts.
- Requests are sampled at edge t. The winner's addr/we/wdata are registered onto ram_* and its gnt=1 during cycle t+1. For a read, the owner's rvalid=1 during t+2 with rdata valid. Writes produce no rvalid.
- At most one grant per cycle. Back-to-back grants every cycle are allowed, including to the same requester.
- A requester holds req/addr/we/wdata stable until it sees gnt. Changing them before gnt is illegal and undefined. It may keep req high to issue the next access, which is resampled the cycle gnt is seen.
- Arbitration order for edge t:
  1. If starve_cnt>=STARVE_LIMIT and (m0_req|m1_req): grant the game requester chosen by rr. VGA is denied.
  2. Else if vga_req: grant VGA.
  3. Else if m0_req&m1_req: grant rr choice. Else grant whichever game requester is active.
- rr pointer: after granting m0 it points to m1; after granting m1 it points to m0. It is unchanged on VGA grant or idle.
- starve_cnt: increments (saturating at STARVE_LIMIT) each edge where m0_req|m1_req and no game grant is issued. It clears to 0 on any game grant, or when no game request is pending.
- While a requester's gnt is high its req is still high (held), but it is not re-arbitrated for that same access. The arbiter masks a requester for the one cycle its gnt is high unless it issues a new access. The rule is implemented as: the request sampled at the edge where gnt=1 is treated as a new access.
- VGA write: not supported. VGA is always a read (ram_we=0).
- Idle cycle: ram_we=0, ram_addr/ram_wdata hold their previous values, all gnt=0.
- Simultaneous read rvalid and new grant in the same cycle is normal pipelining and must both occur.

Optional Feature:
ARB_STATS_EN: when defined, adds input stat_clr (1) and outputs stat_vga_defer (16) and stat_game_wait (16), both saturating at 16'hFFFF.
- stat_vga_defer counts edges where vga_req=1 and VGA was not granted.
- stat_game_wait counts edges where any game request was pending and not granted.
- Both counters clear on reset_reset or stat_clr. stat_clr takes priority over increment.
When undefined: ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Reset mid-read: m0 read granted, reset_reset=1 at the next edge -> m0_rvalid stays 0, all outputs at reset values the following cycle.
- Single read: m1 read addr=8'd37, RAM preloaded 4'hA -> m1_gnt at t+1, ram_addr=37, m1_rvalid=1 and rdata=4'hA at t+2.
- Write then read: m0 writes 4'h5 to addr 12, then reads addr 12 -> ram_we=1 for exactly one cycle, later read returns 4'h5.
- VGA priority: vga_req, m0_req and m1_req all high at one edge -> vga_gnt first; once vga_req drops, grants alternate m0,m1,m0 under continuous requests.
- Starvation: vga_req held high continuously, m1_req high -> VGA granted for STARVE_LIMIT=16 cycles, then m1_gnt=1 once, then VGA resumes.
- Stats (ARB_STATS_EN): scenario above over 20 cycles -> stat_game_wait=16, stat_vga_defer=1; stat_clr=1 -> both read 0 the next cycle.
